sccb_target: RTL and testbench
==============================

SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 SHALL have parameter DEVICE_ID, default 8'h42, 7-bit ID in [7:1] with [0]=0; matches 8'h42 (write) and 8'h43 (read).
REQ-002 SHALL have parameter ACK_ENABLE, default 1, 1 = drive 0 on the 9th bit of accepted bytes.
REQ-003 Port clk, input, 1: single system clock; all state on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port i_scl, input, 1: raw SCCB clock from initiator, asynchronous to clk.
REQ-006 Port io_sda, inout, 1: SCCB data; driven only to 0 or 1 when enabled, otherwise high-Z.
REQ-007 Port o_reg_we, output, 1: one-clk write strobe to external register file.
REQ-008 Port o_reg_addr, output, 8: current subaddress.
REQ-009 Port o_reg_wdata, output, 8: write data, valid when o_reg_we=1.
REQ-010 Port i_reg_rdata, input, 8: register contents at o_reg_addr, combinational from the register file.
REQ-011 Port o_busy, output, 1: high from START to STOP while this device is addressed.

Function
REQ-012 SHALL pass i_scl and io_sda through 2-flop synchronizers, then detect edges on the synchronized copies; i_scl high and low phases must each be >= 4 clk.
REQ-013 START = SDA fall while SCL high; STOP = SDA rise while SCL high; both recognised in any state.
REQ-014 SHALL sample SDA on synced SCL rise; bytes MSB first; 3-bit bit counter, 9th bit handled by the ACK or NA state.
REQ-015 SHALL change the SDA drive only on synced SCL fall, so the drive is stable before the next SCL rise.
REQ-016 States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, DATA, DATA_ACK, READ, READ_NA, IGNORE.
REQ-017 IDLE->ADDR on START; any state->ADDR on repeated START, with the bit counter cleared and the drive released.
REQ-018 After the 8th ADDR bit: ID[7:1] mismatch -> IGNORE (no drive, no strobes) until START or STOP.
REQ-019 On match, the R/W bit (ID[0]) is 0 -> ADDR_ACK->SUB; R/W bit is 1 -> ADDR_ACK->READ, and i_reg_rdata is latched into the shift register at the SCL fall ending ADDR_ACK.
REQ-020 SUB: after 8 bits, o_reg_addr <= received byte, then SUB_ACK->DATA.
REQ-021 DATA: after the 8th bit is sampled, o_reg_wdata <= byte and o_reg_we pulses for exactly 1 clk (3 clk after the pin SCL rise); then DATA_ACK->IGNORE until STOP.
REQ-022 READ: drive 8 bits MSB first, then release the bus in READ_NA; the NA bit is ignored; then IGNORE until STOP.
REQ-023 ACK states drive 0 only when ACK_ENABLE=1; otherwise the 9th bit is not driven.
REQ-024 STOP in any state -> IDLE: release SDA, o_busy=0, o_reg_addr retained.
REQ-025 A STOP after SUB without DATA (2-phase write) SHALL update o_reg_addr only, with no o_reg_we pulse.
REQ-026 No subaddress auto-increment; a read returns the register at the last written subaddress.
REQ-027 A START or STOP mid-byte discards the partial byte; no strobe is issued.

Reset
REQ-028 While rst=1 the following SHALL hold: state=IDLE, SDA released, o_reg_we=0, o_reg_addr=8'h00, o_reg_wdata=8'h00, o_busy=0, synchronizers=1, counter=0.
REQ-029 Reset mid-transfer SHALL release SDA asynchronously; operation resumes only at the next START.

Structure
REQ-030 Package sccb_pkg SHALL hold the state enum, a default-ID constant 8'h42 and the R/W bit index.
REQ-031 Sub-module sccb_sync_edge SHALL hold one 2-flop synchronizer plus rise/fall detect; instantiated twice (SCL, SDA).
REQ-032 The register file SHALL be external to this block.

Verification
REQ-033 Write 42,12,80 then STOP -> one o_reg_we pulse with addr 12 and data 80; SDA=0 on all three 9th bits.
REQ-034 Write 60,12,80 -> SDA never driven, no o_reg_we, o_busy stays 0.
REQ-035 Write 42,0A; STOP; read 43 with i_reg_rdata=76 -> o_reg_addr=0A, no we; SDA bits 0,1,1,1,0,1,1,0; released at NA.
REQ-036 Repeated START after 5 bits of SUB, then 42,33,55 -> single we with addr 33 and data 55.
REQ-037 rst asserted during READ bit 3 -> io_sda high-Z within the same clk; all outputs at reset values.
REQ-038 ACK_ENABLE=0, write 42,12,80 -> we as in REQ-033; SDA never driven.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register target.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_READ,
    ST_READ_NA,
    ST_IGNORE
  } sccb_state_e;

  localparam logic [7:0] SCCB_DEFAULT_ID = 8'h42;
  localparam int         SCCB_RW_BIT     = 0;

  // Only the upper seven bits identify the device; bit 0 carries read/write.
  function automatic logic id_match(input logic [7:0] rx, input logic [7:0] id);
    return rx[7:1] == id[7:1];
  endfunction

endpackage

// File: rtl/sccb_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line, plus rise/fall detection
// on the synchronized copy. Resets to 1 to match an idle, pulled-up bus.
module sccb_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/sccb_target.sv
// SCCB register target: matches a 7-bit device ID, takes one subaddress and one
// data byte per write, and serves one-byte reads from an external register file.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID  = SCCB_DEFAULT_ID,
  parameter bit         ACK_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_scl,
  inout  wire        io_sda,
  output logic       o_reg_we,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy
);

  sccb_state_e state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        ninth_bit;
  logic        sda_oe;
  logic        sda_out;

  logic        scl_level;
  logic        scl_rise;
  logic        scl_fall;
  logic        sda_level;
  logic        sda_rise;
  logic        sda_fall;
  logic        start_cond;
  logic        stop_cond;
  logic [7:0]  rx_byte;

  sccb_sync_edge u_scl_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (i_scl),
    .level    (scl_level),
    .rise     (scl_rise),
    .fall     (scl_fall)
  );

  sccb_sync_edge u_sda_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (io_sda),
    .level    (sda_level),
    .rise     (sda_rise),
    .fall     (sda_fall)
  );

  assign start_cond = scl_level & sda_fall;
  assign stop_cond  = scl_level & sda_rise;
  // Byte as it will look once the bit arriving on this SCL rise is shifted in.
  assign rx_byte    = {shift_reg[6:0], sda_level};

  assign io_sda = sda_oe ? sda_out : 1'bz;

  // The SDA drive only ever changes on a synchronized SCL fall, so it has a
  // whole low phase to settle before the initiator's next rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      shift_reg   <= 8'h00;
      ninth_bit   <= 1'b0;
      sda_oe      <= 1'b0;
      sda_out     <= 1'b1;
      o_reg_we    <= 1'b0;
      o_reg_addr  <= 8'h00;
      o_reg_wdata <= 8'h00;
      o_busy      <= 1'b0;
    end else begin
      o_reg_we <= 1'b0;
      if (start_cond) begin
        state     <= ST_ADDR;
        bit_cnt   <= 3'd0;
        ninth_bit <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_cond) begin
        state     <= ST_IDLE;
        bit_cnt   <= 3'd0;
        ninth_bit <= 1'b0;
        sda_oe    <= 1'b0;
        o_busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_IGNORE: begin
            sda_oe <= 1'b0;
          end

          ST_ADDR: begin
            if (scl_rise) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (id_match(rx_byte, DEVICE_ID)) begin
                  state  <= ST_ADDR_ACK;
                  o_busy <= 1'b1;
                end else begin
                  state  <= ST_IGNORE;
                  o_busy <= 1'b0;
                end
              end
            end
          end

          ST_SUB: begin
            if (scl_rise) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                o_reg_addr <= rx_byte;
                state      <= ST_SUB_ACK;
              end
            end
          end

          ST_DATA: begin
            if (scl_rise) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                o_reg_wdata <= rx_byte;
                o_reg_we    <= 1'b1;
                state       <= ST_DATA_ACK;
              end
            end
          end

          // First SCL fall opens the ninth bit (drive ACK), second one closes it.
          ST_ADDR_ACK, ST_SUB_ACK, ST_DATA_ACK: begin
            if (scl_rise) begin
              ninth_bit <= 1'b1;
            end
            if (scl_fall) begin
              if (!ninth_bit) begin
                sda_oe  <= ACK_ENABLE;
                sda_out <= 1'b0;
              end else begin
                ninth_bit <= 1'b0;
                bit_cnt   <= 3'd0;
                sda_oe    <= 1'b0;
                if (state == ST_ADDR_ACK) begin
                  if (shift_reg[SCCB_RW_BIT]) begin
                    state     <= ST_READ;
                    shift_reg <= i_reg_rdata;
                    sda_oe    <= 1'b1;
                    sda_out   <= i_reg_rdata[7];
                  end else begin
                    state <= ST_SUB;
                  end
                end else if (state == ST_SUB_ACK) begin
                  state <= ST_DATA;
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
          end

          ST_READ: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= ST_READ_NA;
              end
            end
            if (scl_fall) begin
              sda_out   <= shift_reg[6];
              shift_reg <= {shift_reg[6:0], 1'b0};
            end
          end

          // The initiator's NA/ACK bit is not acted on; just release and wait.
          ST_READ_NA: begin
            if (scl_rise) begin
              ninth_bit <= 1'b1;
            end
            if (scl_fall) begin
              sda_oe <= 1'b0;
              if (ninth_bit) begin
                ninth_bit <= 1'b0;
                state     <= ST_IGNORE;
              end
            end
          end

          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// Directed bench for sccb_target: a pin-level SCCB initiator drives two targets
// (ACK enabled and disabled) on separate pulled-up SDA lines sharing SCL.
module tb_sccb_target;

  logic       clk;
  logic       rst;
  logic       scl;
  logic       tb_oe;
  logic       tb_val;
  logic [7:0] rdata;
  wire        sda_bus;
  wire        sda_bus2;

  logic       we1;
  logic       busy1;
  logic [7:0] addr1;
  logic [7:0] wdata1;
  logic       we2;
  logic       busy2;
  logic [7:0] addr2;
  logic [7:0] wdata2;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  int         we_cycles   = 0;
  int         we_cycles2  = 0;
  int         busy_cycles = 0;
  int         low_rel     = 0;
  int         low_rel2    = 0;
  logic [7:0] last_addr   = 8'h00;
  logic [7:0] last_wdata  = 8'h00;
  logic [7:0] last_addr2  = 8'h00;
  logic [7:0] last_wdata2 = 8'h00;

  logic       bit1;
  logic       bit2;

  assign sda_bus  = tb_oe ? tb_val : 1'bz;
  assign sda_bus2 = tb_oe ? tb_val : 1'bz;
  pullup (sda_bus);
  pullup (sda_bus2);

  sccb_target #(
    .DEVICE_ID  (8'h42),
    .ACK_ENABLE (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_scl       (scl),
    .io_sda      (sda_bus),
    .o_reg_we    (we1),
    .o_reg_addr  (addr1),
    .o_reg_wdata (wdata1),
    .i_reg_rdata (rdata),
    .o_busy      (busy1)
  );

  sccb_target #(
    .DEVICE_ID  (8'h42),
    .ACK_ENABLE (1'b0)
  ) dut2 (
    .clk         (clk),
    .rst         (rst),
    .i_scl       (scl),
    .io_sda      (sda_bus2),
    .o_reg_we    (we2),
    .o_reg_addr  (addr2),
    .o_reg_wdata (wdata2),
    .i_reg_rdata (rdata),
    .o_busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-clock tallies of strobes, busy time and target-driven lows on each bus.
  always @(posedge clk) begin
    if (we1) begin
      we_cycles++;
      last_addr  = addr1;
      last_wdata = wdata1;
    end
    if (we2) begin
      we_cycles2++;
      last_addr2  = addr2;
      last_wdata2 = wdata2;
    end
    if (busy1) busy_cycles++;
    if (!tb_oe && sda_bus === 1'b0) low_rel++;
    if (!tb_oe && sda_bus2 === 1'b0) low_rel2++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One SCL period; the initiator drives SDA only when 'drive' is set.
  task automatic clockBit(input logic drive, input logic val);
    #30; tb_oe = drive; tb_val = val;
    #50; scl = 1'b1;
    #40; bit1 = sda_bus; bit2 = sda_bus2;
    #40; scl = 1'b0;
    #20; tb_oe = 1'b0;
  endtask

  task automatic sendStart();
    #30; tb_oe = 1'b1; tb_val = 1'b1;
    #50; scl = 1'b1;
    #40; tb_val = 1'b0;
    #40; scl = 1'b0;
    #20; tb_oe = 1'b0;
  endtask

  task automatic sendStop();
    #30; tb_oe = 1'b1; tb_val = 1'b0;
    #50; scl = 1'b1;
    #40; tb_val = 1'b1;
    #40; tb_oe = 1'b0;
  endtask

  // Sends one byte MSB first, then releases SDA for the ninth bit (left in bit1/bit2).
  task automatic applyStimulus(input logic [7:0] data);
    for (int i = 7; i >= 0; i--) clockBit(1'b1, data[i]);
    clockBit(1'b0, 1'b0);
  endtask

  task automatic readByte(output logic [7:0] b1, output logic [7:0] b2);
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b0, 1'b0);
      b1[i] = bit1;
      b2[i] = bit2;
    end
  endtask

  initial begin
    int         we_base, we_base2, busy_base, low_base, low_base2;
    logic [7:0] rd1, rd2;

    rst = 1'b1; scl = 1'b1; tb_oe = 1'b0; tb_val = 1'b1; rdata = 8'h00;
    #22;
    checkOutput("rst_we",    32'(we1),    32'h0);
    checkOutput("rst_addr",  32'(addr1),  32'h00);
    checkOutput("rst_wdata", 32'(wdata1), 32'h00);
    checkOutput("rst_busy",  32'(busy1),  32'h0);
    checkOutput("rst_sda",   32'(sda_bus), 32'h1);
    #20; rst = 1'b0;

    $display("[TB] full write 42,12,80");
    we_base = we_cycles; we_base2 = we_cycles2; low_base2 = low_rel2;
    sendStart();
    applyStimulus(8'h42);
    checkOutput("a_ack_addr", 32'(bit1), 32'h0);
    checkOutput("a_noack2_addr", 32'(bit2), 32'h1);
    checkOutput("a_busy", 32'(busy1), 32'h1);
    applyStimulus(8'h12);
    checkOutput("a_ack_sub", 32'(bit1), 32'h0);
    checkOutput("a_addr_mid", 32'(addr1), 32'h12);
    applyStimulus(8'h80);
    checkOutput("a_ack_data", 32'(bit1), 32'h0);
    sendStop();
    #40;
    checkOutput("a_we_count", 32'(we_cycles - we_base), 32'd1);
    checkOutput("a_we_addr",  32'(last_addr),  32'h12);
    checkOutput("a_we_data",  32'(last_wdata), 32'h80);
    checkOutput("a_busy_end", 32'(busy1), 32'h0);
    checkOutput("a_addr_kept", 32'(addr1), 32'h12);
    checkOutput("a2_we_count", 32'(we_cycles2 - we_base2), 32'd1);
    checkOutput("a2_we_addr",  32'(last_addr2),  32'h12);
    checkOutput("a2_we_data",  32'(last_wdata2), 32'h80);
    checkOutput("a2_never_driven", 32'(low_rel2 - low_base2), 32'd0);

    $display("[TB] foreign ID 60");
    we_base = we_cycles; busy_base = busy_cycles; low_base = low_rel;
    sendStart();
    applyStimulus(8'h60);
    checkOutput("b_nack", 32'(bit1), 32'h1);
    applyStimulus(8'h12);
    applyStimulus(8'h80);
    sendStop();
    #40;
    checkOutput("b_we_count",   32'(we_cycles - we_base), 32'd0);
    checkOutput("b_busy_count", 32'(busy_cycles - busy_base), 32'd0);
    checkOutput("b_never_driven", 32'(low_rel - low_base), 32'd0);

    $display("[TB] 2-phase write 42,0A then read 43");
    we_base = we_cycles;
    rdata = 8'h76;
    sendStart();
    applyStimulus(8'h42);
    applyStimulus(8'h0A);
    sendStop();
    #40;
    checkOutput("c_addr", 32'(addr1), 32'h0A);
    sendStart();
    applyStimulus(8'h43);
    checkOutput("c_ack_rd", 32'(bit1), 32'h0);
    checkOutput("c_busy_rd", 32'(busy1), 32'h1);
    readByte(rd1, rd2);
    checkOutput("c_rd_byte",  32'(rd1), 32'h76);
    checkOutput("c2_rd_byte", 32'(rd2), 32'h76);
    clockBit(1'b0, 1'b0);
    checkOutput("c_na_released", 32'(bit1), 32'h1);
    sendStop();
    #40;
    checkOutput("c_we_count", 32'(we_cycles - we_base), 32'd0);
    checkOutput("c_addr_after", 32'(addr1), 32'h0A);

    $display("[TB] repeated START inside subaddress byte");
    we_base = we_cycles;
    sendStart();
    applyStimulus(8'h42);
    clockBit(1'b1, 1'b1);
    clockBit(1'b1, 1'b0);
    clockBit(1'b1, 1'b1);
    clockBit(1'b1, 1'b1);
    clockBit(1'b1, 1'b0);
    sendStart();
    checkOutput("d_addr_unchanged", 32'(addr1), 32'h0A);
    applyStimulus(8'h42);
    applyStimulus(8'h33);
    applyStimulus(8'h55);
    sendStop();
    #40;
    checkOutput("d_we_count", 32'(we_cycles - we_base), 32'd1);
    checkOutput("d_we_addr",  32'(last_addr),  32'h33);
    checkOutput("d_we_data",  32'(last_wdata), 32'h55);

    $display("[TB] reset during read bit 3");
    rdata = 8'h00;
    sendStart();
    applyStimulus(8'h43);
    clockBit(1'b0, 1'b0);
    clockBit(1'b0, 1'b0);
    clockBit(1'b0, 1'b0);
    #30; #50; scl = 1'b1;
    #20;
    checkOutput("f_bit3_driven", 32'(sda_bus), 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("f_sda_released",  32'(sda_bus),  32'h1);
    checkOutput("f2_sda_released", 32'(sda_bus2), 32'h1);
    checkOutput("f_we",    32'(we1),    32'h0);
    checkOutput("f_addr",  32'(addr1),  32'h00);
    checkOutput("f_wdata", 32'(wdata1), 32'h00);
    checkOutput("f_busy",  32'(busy1),  32'h0);
    #39; scl = 1'b0;
    #20; rst = 1'b0;

    we_base = we_cycles;
    sendStart();
    applyStimulus(8'h42);
    applyStimulus(8'h5A);
    applyStimulus(8'hA5);
    sendStop();
    #40;
    checkOutput("g_we_count", 32'(we_cycles - we_base), 32'd1);
    checkOutput("g_we_addr",  32'(last_addr),  32'h5A);
    checkOutput("g_we_data",  32'(last_wdata), 32'hA5);

    if (failed != 0) $display("[TB] %0d checks reported errors", failed);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
